alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter XLEN, default 32: datapath width; SHAMT_W = log2(XLEN), 5 at default.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset: synchronous, active-low.
REQ-004 in_valid  input  1  operation offered this cycle.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 alu_op  input  4  operation code from the ALU control generator.
REQ-007 op_a  input  XLEN  first operand.
REQ-008 op_b  input  XLEN  second operand; shift amount = op_b[SHAMT_W-1:0].
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  XLEN  registered result.
REQ-012 zero  output  1  registered flag, high when result == 0.

Function
REQ-013 alu_op encoding SHALL be: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 SRA, 7 OR, 8 AND, 9 SUB.
REQ-014 Codes 10-15 SHALL complete as single-cycle operations with result 0 and zero 1.
REQ-015 Operation accepted on a rising edge where in_valid && in_ready; alu_op, op_a and op_b are captured internally at that edge.
REQ-016 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-017 in_ready SHALL be asserted when state is IDLE, or when state is DONE and out_ready is asserted; it SHALL be deasserted in SHIFT.
REQ-018 Non-shift accept: next state DONE; out_valid rises 1 cycle after accept.
REQ-019 Shift accept (SLL/SRL/SRA) with shamt 0: next state DONE, result = op_a.
REQ-020 Shift accept with shamt > 0: next state SHIFT, counter loaded with shamt.
REQ-021 SHIFT state SHALL shift the working register by exactly one bit per cycle and decrement the counter; it SHALL go to DONE in the cycle the counter equals 1.
REQ-022 Shift latency (accept to out_valid) SHALL be shamt+1 cycles.
REQ-023 Shift fill: SLL and SRL fill with 0; SRA fills with the captured op_a[XLEN-1].
REQ-024 Arithmetic SHALL be modulo 2^XLEN, no overflow flag.
REQ-025 SLT/SLTU SHALL return 1 or 0, zero-extended to XLEN; SLT compares signed, SLTU compares unsigned.
REQ-026 In DONE, out_valid = 1; result and zero SHALL be held stable while out_ready = 0.
REQ-027 DONE with out_ready=1 and in_valid=0: next state IDLE.
REQ-028 DONE with out_ready=1 and in_valid=1: the new operation is accepted in the same cycle (back-to-back, no bubble).
REQ-029 out_valid SHALL be 0 in IDLE and SHIFT.
REQ-030 Inputs SHALL be ignored while in_ready = 0.

Reset
REQ-031 While rst_n = 0 at a clock edge, the block SHALL set: state IDLE, out_valid 0, result 0, zero 0, counter 0, and drop any captured operands.
REQ-032 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no result is delivered for it.
REQ-033 in_ready SHALL be 1 in the first cycle after rst_n is released.

Structure
REQ-034 Package alu_pkg SHALL hold the alu_op localparams (ALU_ADD ... ALU_SUB), the FSM state encoding and the default XLEN; the ALU control generator SHALL share the alu_op localparams.
REQ-035 Sub-module alu_comb SHALL implement the combinational single-cycle operations (all except the iterative shifts); alu_exec owns the FSM, shift register, counter and handshake.

Verification
REQ-036 ADD: op_a=5, op_b=7, accepted cycle 0 -> cycle 1: out_valid=1, result=12, zero=0.
REQ-037 SUB: 3-3 -> result 0, zero 1. SUB: 0-1 -> result 0xFFFFFFFF.
REQ-038 SRA: op_a=0x80000000, op_b=4 -> result 0xF8000000, out_valid exactly 5 cycles after accept, in_ready=0 throughout SHIFT. SLL: op_a=1, op_b=0x25 -> result 0x20 after 6 cycles. SLL with shamt 0 -> result = op_a after 1 cycle.
REQ-039 Backpressure: out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND 0xF0 & 0x3C) -> next cycle result 0x30.
REQ-040 SLT: op_a=0xFFFFFFFF, op_b=5 -> result 1; SLTU with the same operands -> result 0. rst_n=0 during an SRL by 10 -> next cycle IDLE, out_valid=0, result=0, and no stale result appears afterwards.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, FSM state encoding and default datapath width
package alu_pkg;
    localparam int XLEN_DEF = 32;
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SRA  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_AND  = 4'd8;
    localparam logic [3:0] ALU_SUB  = 4'd9;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
    function automatic logic is_shift(input logic [3:0] op);
        return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    endfunction
endpackage

// File: rtl/alu_exec_if.sv
// alu_exec_if: operation request / result handshake bundle
interface alu_exec_if #(parameter int XLEN = alu_pkg::XLEN_DEF);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    modport master (output in_valid, alu_op, op_a, op_b, out_ready,
                    input  in_ready, out_valid, result, zero);
    modport slave  (input  in_valid, alu_op, op_a, op_b, out_ready,
                    output in_ready, out_valid, result, zero);
endinterface

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ALU operations (iterative shifts live in alu_exec)
module alu_comb
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      alu_op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic [XLEN-1:0] result_o
);
    // select the single-cycle result; shifts and unused codes yield 0
    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:  result_o = op_a_i + op_b_i;
            ALU_SUB:  result_o = op_a_i - op_b_i;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(op_a_i) < $signed(op_b_i)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, op_a_i < op_b_i};
            ALU_XOR:  result_o = op_a_i ^ op_b_i;
            ALU_OR:   result_o = op_a_i | op_b_i;
            ALU_AND:  result_o = op_a_i & op_b_i;
            default:  result_o = '0;
        endcase
    end
endmodule

// File: rtl/alu_exec.sv
// alu_exec: ALU execute stage with bit-serial shifter and valid/ready handshake
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus_if
);
    localparam int SW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d, comb_res, shifted;
    logic            zero_q, zero_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            left_q, left_d;
    logic            fill_q, fill_d;
    logic [SW-1:0]   shamt;
    logic            accept;

    alu_comb #(.XLEN(XLEN)) u_comb (
        .alu_op_i (bus_if.alu_op),
        .op_a_i   (bus_if.op_a),
        .op_b_i   (bus_if.op_b),
        .result_o (comb_res)
    );

    assign shamt            = bus_if.op_b[SW-1:0];
    assign bus_if.in_ready  = state_q == ST_IDLE || (state_q == ST_DONE && bus_if.out_ready);
    assign bus_if.out_valid = state_q == ST_DONE;
    assign bus_if.result    = res_q;
    assign bus_if.zero      = zero_q;
    assign accept           = bus_if.in_valid && bus_if.in_ready;
    assign shifted          = left_q ? {res_q[XLEN-2:0], 1'b0} : {fill_q, res_q[XLEN-1:1]};

    // next state: one shift step per cycle in SHIFT, new capture on accept
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        fill_d  = fill_q;
        case (state_q)
            ST_SHIFT: begin
                res_d  = shifted;
                zero_d = shifted == '0;
                cnt_d  = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) state_d = ST_DONE;
            end
            ST_DONE: if (bus_if.out_ready && !bus_if.in_valid) state_d = ST_IDLE;
            default: ;
        endcase
        if (accept) begin
            left_d = bus_if.alu_op == ALU_SLL;
            fill_d = bus_if.alu_op == ALU_SRA && bus_if.op_a[XLEN-1];
            if (is_shift(bus_if.alu_op) && shamt != '0) begin
                state_d = ST_SHIFT;
                res_d   = bus_if.op_a;
                cnt_d   = shamt;
            end else begin
                state_d = ST_DONE;
                res_d   = is_shift(bus_if.alu_op) ? bus_if.op_a : comb_res;
                zero_d  = res_d == '0;
            end
        end
    end

    // state register; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            fill_q  <= fill_d;
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized checks of alu_exec against a latency/result model
module tb_alu_exec;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_exec_if #(.XLEN(32)) bus();
    alu_exec #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return 32'($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SUB:  return a - b;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: an accepted op yields its result after 1 cycle, or shamt+1 for nonzero shifts
    bit          m_pend = 0;
    bit          m_valid = 0;
    int          m_left = 0;
    logic [31:0] m_res = '0;
    logic        m_zero = 1'b0;
    logic        exp_ready;
    assign exp_ready = (!m_pend && !m_valid) || (m_valid && bus.out_ready);

    always @(posedge clk) begin
        bit acc;
        int sh;
        acc = bus.in_valid && exp_ready;
        sh  = int'(bus.op_b[4:0]);
        if (!rst_n) begin
            m_pend = 0; m_valid = 0; m_left = 0; m_res = '0; m_zero = 1'b0;
        end else begin
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin m_pend = 0; m_valid = 1; end
            end else if (m_valid && bus.out_ready) m_valid = 0;
            if (acc) begin
                m_res  = ref_alu(bus.alu_op, bus.op_a, bus.op_b);
                m_zero = m_res == 0;
                if ((bus.alu_op == ALU_SLL || bus.alu_op == ALU_SRL || bus.alu_op == ALU_SRA) && sh != 0) begin
                    m_pend = 1; m_left = sh; m_valid = 0;
                end else m_valid = 1;
            end
        end
    end

    // compare process: handshake every cycle, payload whenever a result is offered
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
            check("model_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("model_result", bus.result, m_res);
                check("model_zero", {31'd0, bus.zero}, {31'd0, m_zero});
            end
        end
    end

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n;
        bit found;
        bus.in_valid = 1'b1; bus.alu_op = op; bus.op_a = a; bus.op_b = b; bus.out_ready = 1'b1;
        #1 check({name, "_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0; found = 0;
        while (n < 40 && !found) begin
            @(negedge clk);
            n++;
            if (bus.out_valid) found = 1;
            else if (lat > 1) check({name, "_shift_ready"}, {31'd0, bus.in_ready}, 32'd0);
        end
        check({name, "_latency"}, n, lat);
        check({name, "_result"}, bus.result, exp);
        check({name, "_zero"}, {31'd0, bus.zero}, {31'd0, exp == 0});
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_op = '0; bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b0;
        check("pin_sra", ref_alu(ALU_SRA, 32'h8000_0000, 32'd4), 32'hF800_0000);
        check("pin_sll", ref_alu(ALU_SLL, 32'd1, 32'h25), 32'h20);
        check("pin_slt", ref_alu(ALU_SLT, 32'hFFFF_FFFF, 32'd5), 32'd1);
        check("pin_sltu", ref_alu(ALU_SLTU, 32'hFFFF_FFFF, 32'd5), 32'd0);
        check("pin_sub", ref_alu(ALU_SUB, 32'd0, 32'd1), 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_zero", {31'd0, bus.zero}, 32'd0);
        @(posedge clk); #1;

        run_op("add", ALU_ADD, 32'd5, 32'd7, 32'd12, 1);
        run_op("sub_eq", ALU_SUB, 32'd3, 32'd3, 32'd0, 1);
        run_op("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1);
        run_op("sra4", ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
        run_op("sll5", ALU_SLL, 32'd1, 32'h25, 32'h20, 6);
        run_op("sll0", ALU_SLL, 32'h0000_ABCD, 32'd0, 32'h0000_ABCD, 1);
        run_op("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd5, 32'd1, 1);
        run_op("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd5, 32'd0, 1);
        run_op("srl31", ALU_SRL, 32'h8000_0000, 32'd31, 32'd1, 32);
        run_op("op12", 4'd12, 32'h1234, 32'h5678, 32'd0, 1);

        bus.in_valid = 1'b1; bus.alu_op = ALU_ADD; bus.op_a = 32'd100; bus.op_b = 32'd23; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_result", bus.result, 32'd123);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.alu_op = ALU_AND; bus.op_a = 32'hF0; bus.op_b = 32'h3C;
        @(negedge clk);
        check("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
        check("b2b_result", bus.result, 32'h30);
        @(posedge clk); #1;

        bus.in_valid = 1'b1; bus.alu_op = ALU_SRL; bus.op_a = 32'hFFFF_0000; bus.op_b = 32'd10;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_zero", {31'd0, bus.zero}, 32'd0);
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_no_stale", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 4000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            bus.in_valid  = $urandom_range(0, 1) == 1;
            bus.alu_op    = sel < 4 ? (sel == 0 ? ALU_SLL : sel == 1 ? ALU_SRL : ALU_SRA) : 4'($urandom_range(0, 15));
            bus.op_a      = sel == 4 ? 32'h8000_0000 : sel == 5 ? 32'hFFFF_FFFF : $urandom;
            bus.op_b      = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : (sel == 6 ? bus.op_a : $urandom);
            bus.out_ready = $urandom_range(0, 3) != 0;
            rst_n         = $urandom_range(0, 399) != 0;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
